// File: rtl/pixel_frame_writer.sv
// Terminal pixel sink: packs PIX_PER_WORD pixels per memory word and writes
// frame-sequential word addresses over a write/waitrequest port.
module pixel_frame_writer #(
  parameter  int unsigned BITS         = 8,
  parameter  int unsigned PIX_PER_WORD = 4,
  parameter  int unsigned WIDTH        = 320,
  parameter  int unsigned HEIGHT       = 240,
  localparam int unsigned WORDS        = WIDTH * HEIGHT / PIX_PER_WORD,
  localparam int unsigned ADDR_W       = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int unsigned WORD_W       = BITS * PIX_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BITS-1:0]   pix_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              clear,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_writedata,
  output logic              mem_write,
  input  logic              mem_waitrequest,
  output logic              frame_done,
  output logic [ADDR_W-1:0] word_count
);

  localparam int unsigned LANE_W = $clog2(PIX_PER_WORD);
  localparam int unsigned ASM_W  = BITS * (PIX_PER_WORD - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              frame_done_q, frame_done_d;

  logic last_lane;
  logic drain;
  logic accept;
  logic load;

  // The final lane may only enter when the output register is free or leaving.
  assign last_lane = (lane_q == LAST_LANE);
  assign drain     = out_valid_q && !mem_waitrequest;
  assign ready_out = !last_lane || !out_valid_q || !mem_waitrequest;
  assign accept    = valid_in && ready_out && !clear;
  assign load      = accept && last_lane;

  always_comb begin
    lane_d       = lane_q;
    asm_d        = asm_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wcnt_d       = wcnt_q;
    frame_done_d = drain && out_last_q;

    if (drain) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      lane_d = '0;
      asm_d  = '0;
      wcnt_d = '0;
    end else if (accept) begin
      if (last_lane) begin
        lane_d      = '0;
        data_d      = {pix_in, asm_q};
        addr_d      = wcnt_q;
        out_last_d  = (wcnt_q == LAST_ADDR);
        out_valid_d = 1'b1;
        wcnt_d      = (wcnt_q == LAST_ADDR) ? '0 : wcnt_q + ADDR_W'(1);
      end else begin
        lane_d = lane_q + LANE_W'(1);
        for (int k = 0; k < int'(PIX_PER_WORD) - 1; k++) begin
          if (lane_q == LANE_W'(k)) begin
            asm_d[k*BITS +: BITS] = pix_in;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q       <= '0;
      asm_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wcnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wcnt_q       <= wcnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // load is consumed through out_valid_d; keep it visible for readers of the datapath.
  logic unused_load;
  assign unused_load = load;

  assign mem_address   = addr_q;
  assign mem_writedata = data_q;
  assign mem_write     = out_valid_q;
  assign frame_done    = frame_done_q;
  assign word_count    = wcnt_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Randomized bench for pixel_frame_writer against a queue-based frame model.
module tb_pixel_frame_writer;

  localparam int unsigned BITS  = 8;
  localparam int unsigned N     = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned WORDS = W * H / N;
  localparam int unsigned AW    = 1;
  localparam int unsigned DW    = BITS * N;

  logic            clk = 1'b0;
  logic            reset;
  logic [BITS-1:0] pix_in;
  logic            valid_in;
  logic            ready_out;
  logic            clear;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_writedata;
  logic            mem_write;
  logic            mem_waitrequest;
  logic            frame_done;
  logic [AW-1:0]   word_count;

  pixel_frame_writer #(.BITS(BITS), .PIX_PER_WORD(N), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .valid_in(valid_in),
    .ready_out(ready_out), .clear(clear), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_write(mem_write),
    .mem_waitrequest(mem_waitrequest), .frame_done(frame_done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pixels of the word being gathered, words handed to memory but not yet written.
  logic [BITS-1:0] pixq[$];
  logic [DW-1:0]   exp_data[$];
  int              exp_addr[$];
  int              word_idx = 0;
  bit              fd_next = 1'b0;
  int              fd_seen = 0;
  logic [BITS-1:0] src[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pixq.delete();
    exp_data.delete();
    exp_addr.delete();
    word_idx = 0;
    fd_next  = 1'b0;
  endtask

  // One clock: drive inputs, check at negedge, advance the model, return after posedge.
  task automatic cycle(input bit v, input logic [BITS-1:0] p, input bit clr,
                       input bit wr, output bit acc);
    bit exp_rdy;
    bit pend;
    logic [DW-1:0] w;
    valid_in = v; pix_in = p; clear = clr; mem_waitrequest = wr;
    @(negedge clk);
    pend = (exp_data.size() != 0);
    chk("frame_done", 32'(frame_done), 32'(fd_next));
    chk("word_count", 32'(word_count), 32'(word_idx));
    chk("mem_write", 32'(mem_write), 32'(pend));
    if (mem_write && pend) begin
      chk("mem_address", 32'(mem_address), 32'(exp_addr[0]));
      chk("mem_writedata", 32'(mem_writedata), 32'(exp_data[0]));
    end
    exp_rdy = !(pixq.size() == N - 1 && pend && wr);
    chk("ready_out", 32'(ready_out), 32'(exp_rdy));
    if (frame_done) fd_seen++;
    fd_next = 1'b0;
    if (pend && !wr) begin
      fd_next = (exp_addr[0] == WORDS - 1);
      void'(exp_data.pop_front());
      void'(exp_addr.pop_front());
    end
    acc = v && exp_rdy && !clr;
    if (clr) begin
      pixq.delete();
      word_idx = 0;
    end else if (acc) begin
      pixq.push_back(p);
      if (pixq.size() == N) begin
        w = '0;
        for (int k = 0; k < N; k++) w = w | (DW'(pixq[k]) << (k * BITS));
        exp_data.push_back(w);
        exp_addr.push_back(word_idx);
        word_idx = (word_idx + 1) % WORDS;
        pixq.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
  endtask

  // Push src through the DUT with random valid gaps/stalls; first_stall stalls the first write.
  task automatic run_stream(input int gap_pct, input int stall_pct, input int first_stall);
    bit acc;
    bit v;
    bit wr;
    logic [BITS-1:0] p;
    int stall_left = first_stall;
    for (int c = 0; c < 2000 && (src.size() != 0 || exp_data.size() != 0); c++) begin
      v = (src.size() != 0) && ($urandom_range(99) >= gap_pct);
      p = v ? src[0] : BITS'($urandom);
      if (stall_left > 0 && mem_write) begin
        wr = 1'b1;
        stall_left--;
      end else begin
        wr = ($urandom_range(99) < stall_pct);
      end
      cycle(v, p, 1'b0, wr, acc);
      if (acc) void'(src.pop_front());
    end
    chk("stream_drained", 32'(src.size() + exp_data.size()), 32'd0);
    idle(2);
  endtask

  task automatic push_seq(input int first, input int count);
    for (int i = 0; i < count; i++) src.push_back(BITS'(first + i));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_writedata", 32'(mem_writedata), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    bit acc;
    int fd0;
    reset = 1'b1; valid_in = 1'b0; pix_in = '0; clear = 1'b0; mem_waitrequest = 1'b0;
    #12;
    chk("init_mem_write", 32'(mem_write), 32'd0);
    chk("init_word_count", 32'(word_count), 32'd0);
    chk("init_frame_done", 32'(frame_done), 32'd0);
    chk("init_ready", 32'(ready_out), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full frame, no stalls, continuous valid.
    fd0 = fd_seen;
    push_seq(1, 8);
    run_stream(0, 0, 0);
    chk("frame1_pulses", 32'(fd_seen - fd0), 32'd1);

    // Same frame with the first write stalled five cycles.
    fd0 = fd_seen;
    push_seq(1, 8);
    run_stream(0, 0, 5);
    chk("frame2_pulses", 32'(fd_seen - fd0), 32'd1);

    // Clear drops the partial word and the pixel presented with it.
    src.push_back(8'hAA);
    src.push_back(8'hBB);
    run_stream(0, 0, 0);
    cycle(1'b1, 8'hCC, 1'b1, 1'b0, acc);
    push_seq(1, 4);
    run_stream(0, 0, 0);

    // Async reset mid-word, then a fresh word lands at address 0.
    cycle(1'b1, 8'h11, 1'b0, 1'b0, acc);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, acc);
    do_reset();
    push_seq(8'h31, 4);
    run_stream(0, 0, 0);

    // Async reset while a write is stalled.
    for (int i = 0; i < 4; i++) cycle(1'b1, BITS'(8'h41 + i), 1'b0, 1'b1, acc);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
    do_reset();
    push_seq(8'h51, 4);
    run_stream(0, 0, 0);

    // Clear while a word is pending: the pending write still finishes.
    for (int i = 0; i < 4; i++) cycle(1'b1, BITS'(8'h61 + i), 1'b0, 1'b1, acc);
    cycle(1'b1, 8'h70, 1'b1, 1'b1, acc);
    run_stream(0, 30, 0);

    // Two frames with random gaps and random stalls.
    fd0 = fd_seen;
    for (int i = 0; i < 16; i++) src.push_back(BITS'($urandom));
    run_stream(30, 40, 0);
    chk("rand_frame_pulses", 32'(fd_seen - fd0), 32'd2);

    // Longer random soak over several frames.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) src.push_back(BITS'($urandom));
      run_stream($urandom_range(50), $urandom_range(60), $urandom_range(4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
- Terminal sink for the filtered pixel stream. It consumes the valid/ready pixel output of the filter chain and supplies the upstream ready signal.
- Packs PIX_PER_WORD pixels into one memory word and issues word writes over a simple write/waitrequest memory port.
- Word addresses run sequentially and wrap once per frame; a pulse marks each completed frame.

Parameters:
- BITS, 8, pixel width in bits.
- PIX_PER_WORD, 4, pixels packed per memory word (>=2).
- WIDTH, 320, frame width in pixels.
- HEIGHT, 240, frame height in pixels. WIDTH*HEIGHT must be divisible by PIX_PER_WORD.
- WORDS (derived), WIDTH*HEIGHT/PIX_PER_WORD, words per frame.
- ADDR_W (derived), $clog2(WORDS), word-address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- pix_in  in  BITS  incoming pixel.
- valid_in  in  1  pix_in valid.
- ready_out  out  1  this block can accept a pixel this cycle.
- clear  in  1  synchronous restart of packing and addressing.
- mem_address  out  ADDR_W  word address of the pending write.
- mem_writedata  out  BITS*PIX_PER_WORD  packed word.
- mem_write  out  1  write request.
- mem_waitrequest  in  1  memory stall; a write completes on a cycle with mem_write=1 and mem_waitrequest=0.
- frame_done  out  1  one-cycle pulse after the last word of a frame completes.
- word_count  out  ADDR_W  address of the next word to be assembled (observability).

Behaviour:
- Reset (async): lane=0, assembly register=0, out_valid=0, mem_address=0, mem_writedata=0, word_count=0, frame_done=0. Any partial word is discarded.
- Pixel accept: a pixel is accepted on a cycle where valid_in=1 and ready_out=1.
- ready_out is combinational: ready_out = (lane != PIX_PER_WORD-1) || !out_valid || !mem_waitrequest.
  - Lanes 0..N-2 are always accepted.
  - The final lane is accepted only if the output register is empty or is draining in the same cycle.
- Packing: the first pixel of a word goes to bits [BITS-1:0] and lane k to bits [(k+1)*BITS-1:k*BITS]. lane increments on each accept.
- Word load: on accepting lane N-1:
  - mem_writedata is loaded with {pix_in, assembly lanes N-2..0} and mem_address with word_count.
  - out_valid=1, lane goes to 0.
  - word_count increments, wrapping WORDS-1 -> 0.
  - out_last is set when the loaded address equals WORDS-1.
- Memory write: mem_write = out_valid.
  - While mem_waitrequest=1, mem_address and mem_writedata are held stable.
  - On completion, out_valid clears unless a new word loads in the same cycle; in that case out_valid stays 1 with the new data. No bubble is required.
- frame_done: registered, asserted the cycle after completion of a write with out_last=1, for exactly one cycle.
- Latency: the write request is asserted the cycle after the final-lane pixel is accepted.
- Throughput: 1 pixel/cycle with mem_waitrequest=0.
- clear (sync, takes priority over a pixel accept in the same cycle):
  - lane=0, assembly discarded, word_count=0.
  - A pending output word is not cancelled; it completes normally, and out_last/frame_done behave per its loaded address.
  - The pixel presented with clear is dropped, and ready_out still reflects the formula above.
- Backpressure chain: while the final lane is blocked, ready_out=0 and pix_in is not sampled. Upstream must hold pix_in/valid_in.
- Arithmetic: word_count and mem_address are unsigned ADDR_W. Wrap occurs exactly at WORDS-1 and never reaches 2^ADDR_W-1 unless WORDS=2^ADDR_W.

Test Plan:
- Params WIDTH=4, HEIGHT=2, N=4 (WORDS=2); stream pixels 0x01..0x08 with valid_in=1 and waitrequest=0 -> writes 0x04030201@0 and 0x08070605@1; frame_done pulses one cycle after the second write; word_count returns to 0.
- Same frame, waitrequest=1 for 5 cycles on the first write -> address 0 and data 0x04030201 held for 6 cycles; ready_out=0 while lane=3 is pending; no pixel lost; second word is correct.
- Back-to-back load and drain: waitrequest=0 and continuous valid -> mem_write asserts for word 0, deasserts for three cycles, then asserts for word 1; ready_out never drops.
- Send 0xAA, 0xBB, then clear=1 with pixel 0xCC, then 0x01..0x04 -> single write 0x04030201@0; 0xAA, 0xBB, 0xCC absent.
- Assert async reset mid-word (lane=2) and during a stalled write -> all outputs 0 immediately; the next four pixels produce a write at address 0.
- Two full frames streamed with random valid gaps and random waitrequest -> data matches the scoreboard, addresses 0,1,0,1, and exactly two frame_done pulses.
